// File: rtl/readout_ctrl.sv
// Frame readout controller: freezes the columns, strobes one Read per word,
// spaces words by WORD_CYCLES and closes the frame with a hold-off.
module readout_ctrl #(
    parameter int unsigned FREEZE_WAIT = 4,
    parameter int unsigned WORD_CYCLES = 27,
    parameter int unsigned MAX_WORDS   = 1024,
    parameter int unsigned HOLDOFF     = 2
) (
    input  logic        ClkOut,
    input  logic        Reset,
    input  logic        Enable,
    input  logic        TokenIn,
    output logic        Freeze,
    output logic        Read,
    output logic        Busy,
    output logic [15:0] WordCount,
    output logic        FrameDone,
    output logic        Truncated
);

    typedef enum logic [2:0] {
        IDLE,
        FREEZE,
        READ,
        WAIT,
        DONE
    } state_t;

    localparam logic [7:0]  FW_LOAD = 8'(FREEZE_WAIT - 1);
    localparam logic [7:0]  WC_LOAD = 8'(WORD_CYCLES - 2);
    localparam logic [7:0]  HO_LOAD = 8'(HOLDOFF - 1);
    localparam logic [15:0] WC_MAX  = 16'(MAX_WORDS);

    state_t      state;
    state_t      state_nx;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nx;
    logic [15:0] words_nx;
    logic        freeze_nx;
    logic        read_nx;
    logic        busy_nx;
    logic        done_nx;
    logic        trunc_nx;

    logic go;
    logic cnt_zero;
    logic at_max;
    logic enter_read;
    logic enter_done;
    logic trunc_end;

    assign go       = Enable & TokenIn;
    assign cnt_zero = (cnt == 8'd0);
    assign at_max   = (WordCount == WC_MAX);

    always_ff @(posedge ClkOut or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            WordCount <= 16'd0;
            Freeze    <= 1'b0;
            Read      <= 1'b0;
            Busy      <= 1'b0;
            FrameDone <= 1'b0;
            Truncated <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            WordCount <= words_nx;
            Freeze    <= freeze_nx;
            Read      <= read_nx;
            Busy      <= busy_nx;
            FrameDone <= done_nx;
            Truncated <= trunc_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        words_nx   = WordCount;
        freeze_nx  = 1'b0;
        read_nx    = 1'b0;
        done_nx    = 1'b0;
        trunc_nx   = 1'b0;
        enter_read = 1'b0;
        enter_done = 1'b0;
        trunc_end  = 1'b0;

        unique case (state)
            IDLE: begin
                if (go) begin
                    state_nx  = FREEZE;
                    cnt_nx    = FW_LOAD;
                    words_nx  = 16'd0;
                    freeze_nx = 1'b1;
                end
            end
            FREEZE: begin
                freeze_nx = 1'b1;
                if (!cnt_zero) begin
                    cnt_nx = cnt - 8'd1;
                end else if (go) begin
                    enter_read = 1'b1;
                end else begin
                    enter_done = 1'b1;
                end
            end
            READ: begin
                freeze_nx = 1'b1;
                state_nx  = WAIT;
                cnt_nx    = WC_LOAD;
            end
            WAIT: begin
                freeze_nx = 1'b1;
                if (!cnt_zero) begin
                    cnt_nx = cnt - 8'd1;
                end else if (at_max) begin
                    enter_done = 1'b1;
                    trunc_end  = 1'b1;
                end else if (!go) begin
                    enter_done = 1'b1;
                end else begin
                    enter_read = 1'b1;
                end
            end
            DONE: begin
                if (cnt_zero) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 8'd1;
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = 8'd0;
            end
        endcase

        // Count is bumped as the strobe is issued so WAIT sees the new total
        if (enter_read) begin
            state_nx  = READ;
            read_nx   = 1'b1;
            freeze_nx = 1'b1;
            words_nx  = at_max ? WordCount : WordCount + 16'd1;
        end

        if (enter_done) begin
            state_nx  = DONE;
            cnt_nx    = HO_LOAD;
            freeze_nx = 1'b0;
            done_nx   = 1'b1;
            trunc_nx  = trunc_end;
        end
    end

    assign busy_nx = (state_nx != IDLE);

endmodule

// File: tb/tb_readout_ctrl.sv
// Bench for readout_ctrl: frame-level vector table, corner sequences and
// random stimulus checked every cycle against a timeline model.
module tb_readout_ctrl;

    localparam int FW_A = 4;
    localparam int WC_A = 27;
    localparam int MW_A = 1024;
    localparam int HO_A = 2;
    localparam int FW_B = 2;
    localparam int WC_B = 4;
    localparam int MW_B = 3;
    localparam int HO_B = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en_a = 1'b0, tok_a = 1'b0;
    logic en_b = 1'b0, tok_b = 1'b0;
    logic fz_a, rd_a, bz_a, fd_a, tr_a;
    logic fz_b, rd_b, bz_b, fd_b, tr_b;
    logic [15:0] wc_a, wc_b;

    readout_ctrl #(
        .FREEZE_WAIT(FW_A), .WORD_CYCLES(WC_A),
        .MAX_WORDS(MW_A), .HOLDOFF(HO_A)
    ) dut_a (
        .ClkOut(clk), .Reset(rst), .Enable(en_a), .TokenIn(tok_a),
        .Freeze(fz_a), .Read(rd_a), .Busy(bz_a), .WordCount(wc_a),
        .FrameDone(fd_a), .Truncated(tr_a)
    );

    readout_ctrl #(
        .FREEZE_WAIT(FW_B), .WORD_CYCLES(WC_B),
        .MAX_WORDS(MW_B), .HOLDOFF(HO_B)
    ) dut_b (
        .ClkOut(clk), .Reset(rst), .Enable(en_b), .TokenIn(tok_b),
        .Freeze(fz_b), .Read(rd_b), .Busy(bz_b), .WordCount(wc_b),
        .FrameDone(fd_b), .Truncated(tr_b)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t",
                      name, act, exp, $time);
    endtask

    // Frame timeline model: t counts cycles since Freeze rose; words are
    // strobed at t = FW + k*WC and decisions fall one cycle before that.
    typedef struct {
        int phase;
        int t;
        int words;
        int age;
        bit fz, rd, bz, fd, tr;
    } mdl_t;

    function automatic mdl_t step(mdl_t m, int fw, int wc, int mw, int ho,
                                  bit en, bit tok, bit r);
        mdl_t n;
        int   k;
        n = m;
        n.rd = 0;
        n.fd = 0;
        n.tr = 0;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        if (m.phase == 0) begin
            if (en && tok) begin
                n.phase = 1; n.t = 0; n.words = 0; n.fz = 1; n.bz = 1;
            end
        end else if (m.phase == 1) begin
            n.t = m.t + 1;
            if (m.t + 1 >= fw && (m.t + 1 - fw) % wc == 0) begin
                k = (m.t + 1 - fw) / wc;
                if ((k > 0 && m.words == mw) || !(en && tok)) begin
                    n.phase = 2; n.age = 1; n.fz = 0; n.fd = 1;
                    n.tr = (k > 0 && m.words == mw);
                end else begin
                    n.rd = 1;
                    n.words = m.words + 1;
                end
            end
        end else begin
            if (m.age >= ho) begin
                n.phase = 0; n.bz = 0;
            end else begin
                n.age = m.age + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [20:0] mvec(mdl_t m);
        return {m.fz, m.rd, m.bz, m.fd, m.tr, 16'(m.words)};
    endfunction

    mdl_t ma = '{default: 0};
    mdl_t mb = '{default: 0};
    bit   s_rst, s_ea, s_ta, s_eb, s_tb;

    int cyc = 0;
    bit prev_fz = 0, prev_fz_b = 0;
    int frise, first_lat, last_rd, gap_min, gap_max;
    int reads_a, fz_cnt, fz_rises, fd_cnt, tr_cnt;
    int reads_b, fd_cnt_b, done_cyc_b, rise_b_cyc;

    task automatic clr_stats();
        frise = 0; first_lat = -1; last_rd = 0;
        gap_min = 1000000; gap_max = 0;
        reads_a = 0; fz_cnt = 0; fz_rises = 0; fd_cnt = 0; tr_cnt = 0;
        reads_b = 0; fd_cnt_b = 0; done_cyc_b = 0; rise_b_cyc = -1;
    endtask

    always @(posedge clk) begin
        s_rst = rst; s_ea = en_a; s_ta = tok_a; s_eb = en_b; s_tb = tok_b;
        #1;
        ma = step(ma, FW_A, WC_A, MW_A, HO_A, s_ea, s_ta, s_rst);
        mb = step(mb, FW_B, WC_B, MW_B, HO_B, s_eb, s_tb, s_rst);
        chk("cycle_a", {fz_a, rd_a, bz_a, fd_a, tr_a, wc_a}, mvec(ma));
        chk("cycle_b", {fz_b, rd_b, bz_b, fd_b, tr_b, wc_b}, mvec(mb));
        cyc++;
        if (fz_a && !prev_fz) begin
            fz_rises++;
            frise = cyc;
        end
        prev_fz = fz_a;
        if (fz_a) fz_cnt++;
        if (rd_a) begin
            if (reads_a == 0) first_lat = cyc - frise;
            else begin
                if (cyc - last_rd < gap_min) gap_min = cyc - last_rd;
                if (cyc - last_rd > gap_max) gap_max = cyc - last_rd;
            end
            last_rd = cyc;
            reads_a++;
        end
        if (fd_a) fd_cnt++;
        if (tr_a) tr_cnt++;
        if (fd_b) begin
            fd_cnt_b++;
            done_cyc_b = cyc;
        end
        if (rd_b) reads_b++;
        if (fz_b && !prev_fz_b) rise_b_cyc = cyc;
        prev_fz_b = fz_b;
    end

    typedef struct {
        string name;
        int    tok_low;
        int    en_low;
        int    reads;
        int    words;
        int    fz_len;
        int    trunc;
    } vec_t;

    vec_t vt[4];
    int   budget;

    initial begin
        vt[0] = '{"single_hit", 5,   0,  1, 1, FW_A + WC_A,     0};
        vt[1] = '{"burst5",     113, 0,  5, 5, FW_A + 5 * WC_A, 0};
        vt[2] = '{"en_drop",    0,   40, 2, 2, FW_A + 2 * WC_A, 0};
        vt[3] = '{"tok_vanish", 2,   0,  0, 0, FW_A,            0};
        clr_stats();

        repeat (2) @(negedge clk);
        chk("reset_a", {fz_a, rd_a, bz_a, fd_a, tr_a, wc_a}, 0);
        chk("reset_b", {fz_b, rd_b, bz_b, fd_b, tr_b, wc_b}, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 4; i++) begin
            clr_stats();
            en_a = 1'b1;
            tok_a = 1'b1;
            for (int off = 1; off < 400 && fd_cnt == 0; off++) begin
                @(negedge clk);
                tok_a = (vt[i].tok_low == 0 || off < vt[i].tok_low);
                en_a  = (vt[i].en_low == 0 || off < vt[i].en_low);
            end
            en_a = 1'b0;
            tok_a = 1'b0;
            repeat (HO_A + 3) @(negedge clk);
            chk({vt[i].name, "_reads"}, reads_a, vt[i].reads);
            chk({vt[i].name, "_words"}, wc_a, vt[i].words);
            chk({vt[i].name, "_freeze_len"}, fz_cnt, vt[i].fz_len);
            chk({vt[i].name, "_freeze_rises"}, fz_rises, 1);
            chk({vt[i].name, "_framedone"}, fd_cnt, 1);
            chk({vt[i].name, "_truncated"}, tr_cnt, vt[i].trunc);
            if (vt[i].reads > 0)
                chk({vt[i].name, "_first_lat"}, first_lat, FW_A);
            if (vt[i].reads > 1) begin
                chk({vt[i].name, "_gap_min"}, gap_min, WC_A);
                chk({vt[i].name, "_gap_max"}, gap_max, WC_A);
            end
        end

        // Truncation on the small instance with the token held high
        clr_stats();
        en_b = 1'b1;
        tok_b = 1'b1;
        budget = 0;
        while (fd_cnt_b == 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        chk("trunc_timeout", fd_cnt_b, 1);
        chk("trunc_flag", tr_b, 1);
        chk("trunc_freeze_low", fz_b, 0);
        chk("trunc_words", wc_b, MW_B);
        chk("trunc_reads", reads_b, MW_B);
        budget = 0;
        while (rise_b_cyc <= done_cyc_b && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("trunc_restart", rise_b_cyc - done_cyc_b, HO_B + 1);
        en_b = 1'b0;
        tok_b = 1'b0;
        repeat (10) @(negedge clk);

        // Asynchronous reset in the middle of WAIT
        clr_stats();
        en_a = 1'b1;
        tok_a = 1'b1;
        repeat (10) @(negedge clk);
        chk("pre_reset_busy", bz_a, 1);
        rst = 1'b1;
        #1;
        chk("async_reset", {fz_a, rd_a, bz_a, fd_a, tr_a, wc_a}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_no_done", fd_cnt, 0);
        chk("reset_restart", fz_a, 1);
        tok_a = 1'b0;
        en_a = 1'b0;
        repeat (FW_A + HO_A + 4) @(negedge clk);

        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            en_a  = ($urandom_range(0, 99) < 88);
            tok_a = ($urandom_range(0, 99) < 75);
            en_b  = ($urandom_range(0, 99) < 85);
            tok_b = ($urandom_range(0, 99) < 70);
            if (rst) rst = ($urandom_range(0, 1) == 0);
            else     rst = ($urandom_range(0, 399) == 0);
        end
        rst = 1'b0;
        en_a = 1'b0; tok_a = 1'b0; en_b = 1'b0; tok_b = 1'b0;
        repeat (40) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/readout_ctrl.md
READOUT_CTRL -- requirements
Module: readout_ctrl

Interface
REQ-001 SHALL have parameter FREEZE_WAIT, default 4: cycles Freeze is held before the first Read (range 1..255).
REQ-002 SHALL have parameter WORD_CYCLES, default 27: ClkOut cycles reserved per read word for serialization (range 2..255).
REQ-003 SHALL have parameter MAX_WORDS, default 1024: maximum words per frame before truncation (range 1..65535).
REQ-004 SHALL have parameter HOLDOFF, default 2: idle cycles after a frame before a new frame may start (range 1..255).
REQ-005 SHALL have port ClkOut, input, 1: single clock; all state changes on its rising edge.
REQ-006 SHALL have port Reset, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port Enable, input, 1: global readout enable.
REQ-008 SHALL have port TokenIn, input, 1: chip token; high = pending hits in some enabled column.
REQ-009 SHALL have port Freeze, output, 1: freezes column contents for a frame.
REQ-010 SHALL have port Read, output, 1: one-cycle strobe, one word per pulse.
REQ-011 SHALL have port Busy, output, 1: high in any state other than IDLE.
REQ-012 SHALL have port WordCount, output, 16: words read in the current or last frame.
REQ-013 SHALL have port FrameDone, output, 1: one-cycle pulse at frame end.
REQ-014 SHALL have port Truncated, output, 1: one-cycle pulse, coincident with FrameDone, when a frame ended on MAX_WORDS.

Function
REQ-015 SHALL implement states IDLE, FREEZE, READ, WAIT, DONE; all outputs registered.
REQ-016 IDLE: Freeze=0, Read=0; if Enable=1 and TokenIn=1, SHALL go to FREEZE, clear WordCount, load counter with FREEZE_WAIT-1.
REQ-017 FREEZE: Freeze=1; SHALL count down; at zero go to READ if Enable=1 and TokenIn=1, else DONE.
REQ-018 READ: SHALL assert Read for exactly one cycle, increment WordCount, load counter with WORD_CYCLES-2, go to WAIT.
REQ-019 WAIT: Freeze=1, Read=0; at counter zero SHALL decide, in priority order: WordCount==MAX_WORDS -> DONE with truncation; Enable=0 or TokenIn=0 -> DONE; else READ.
REQ-020 Consecutive Read pulses SHALL be exactly WORD_CYCLES cycles apart.
REQ-021 DONE: Freeze=0 from first DONE cycle; FrameDone (and Truncated if applicable) high for that first cycle only; SHALL stay HOLDOFF cycles then go to IDLE.
REQ-022 Latency: TokenIn sampled high in IDLE at edge N -> Freeze=1 after edge N; first Read high FREEZE_WAIT cycles after Freeze rises.
REQ-023 TokenIn or Enable changes SHALL only be acted on at IDLE and at FREEZE/WAIT decision points; no Read is issued when Enable=0 at the decision point.
REQ-024 WordCount SHALL saturate at MAX_WORDS, never wrap, and hold its value through DONE and IDLE until the next frame starts.
REQ-025 Freeze SHALL be high continuously from frame start through the last WAIT cycle, with no glitch between words.

Reset
REQ-026 Reset=1 SHALL immediately force IDLE, counter=0, WordCount=0, Freeze=0, Read=0, Busy=0, FrameDone=0, Truncated=0, regardless of state.
REQ-027 Reset asserted mid-frame SHALL produce no FrameDone pulse; after release, a new frame starts only per REQ-016.

Verification
REQ-028 Single hit: TokenIn high, then low one cycle after the first Read -> Freeze high 4+27=31 cycles, one Read, WordCount=1, FrameDone pulse, Truncated=0.
REQ-029 Burst: TokenIn high for 5 words -> 5 Read pulses 27 cycles apart, WordCount=5, single FrameDone.
REQ-030 Truncation with MAX_WORDS=3, TokenIn held high -> 3 Reads, FrameDone and Truncated together, Freeze low, new frame after HOLDOFF=2 idle cycles.
REQ-031 Enable dropped during WAIT of word 2 -> no 3rd Read, DONE at that WAIT's end, WordCount=2.
REQ-032 Token vanishes during FREEZE -> zero Reads, WordCount=0, FrameDone pulse.
REQ-033 Reset pulsed in WAIT -> all outputs 0 within the reset cycle (async), no FrameDone; frame restarts if TokenIn still high after release.
